arbiter_rr_burst: RTL and testbench

// Round-robin arbiter sharing the val/rdy SPI send channel among ninputs packet sources.

---
 rtl/arbiter_rr_burst.sv | 110 +++++++++++
 tb/tb_arbiter_rr_burst.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_burst.sv
// rtl/arbiter_rr_burst.sv - round-robin burst arbiter feeding a registered val/rdy output stage
module arbiter_rr_burst #(
    parameter int nbits      = 32,
    parameter int ninputs    = 3,
    parameter int burst_len  = 4,
    parameter int addr_nbits = $clog2(ninputs)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ninputs-1:0]                istream_val,
    output logic [ninputs-1:0]                istream_rdy,
    input  logic [ninputs-1:0][nbits-1:0]     istream_msg,
    output logic                              ostream_val,
    input  logic                              ostream_rdy,
    output logic [addr_nbits+nbits-1:0]       ostream_msg,
    output logic [addr_nbits-1:0]             grant_idx,
    output logic                              busy
);
    localparam int CW = $clog2(burst_len + 1);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]                  r_state;
    logic [addr_nbits-1:0]       r_rr_ptr;
    logic [addr_nbits-1:0]       r_grant;
    logic [CW-1:0]               r_beat_cnt;
    logic                        r_oval;
    logic [addr_nbits+nbits-1:0] r_omsg;

    logic                        w_found;
    logic [addr_nbits-1:0]       w_pick;
    logic [addr_nbits:0]         w_sum;
    logic                        w_out_free;
    logic                        w_xfer;
    logic                        w_last;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = ninputs - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (addr_nbits + 1)'(k);
            if (w_sum >= (addr_nbits + 1)'(ninputs)) begin
                w_sum = w_sum - (addr_nbits + 1)'(ninputs);
            end
            if (istream_val[w_sum[addr_nbits-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[addr_nbits-1:0];
            end
        end
    end

    assign w_out_free = !r_oval || ostream_rdy;
    assign w_xfer     = (r_state == ST_BURST) && istream_val[r_grant] && w_out_free;
    assign w_last     = (r_beat_cnt == CW'(burst_len - 1));

    always_comb begin
        istream_rdy = '0;
        for (int i = 0; i < ninputs; i++) begin
            istream_rdy[i] = (r_state == ST_BURST) && (r_grant == addr_nbits'(i)) && w_out_free;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_oval     <= 1'b0;
            r_omsg     <= '0;
        end else begin
            // A fresh beat takes priority over draining the output register.
            if (w_xfer) begin
                r_omsg <= {r_grant, istream_msg[r_grant]};
                r_oval <= 1'b1;
            end else if (ostream_rdy) begin
                r_oval <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BURST;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state    <= ST_IDLE;
                            r_beat_cnt <= '0;
                            r_rr_ptr   <= (r_grant == addr_nbits'(ninputs - 1)) ? '0
                                                                                : r_grant + addr_nbits'(1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign ostream_val = r_oval;
    assign ostream_msg = r_omsg;
    assign grant_idx   = r_grant;
    assign busy        = (r_state == ST_BURST);
endmodule

// File: tb/tb_arbiter_rr_burst.sv
// tb/tb_arbiter_rr_burst.sv - scoreboard bench for arbiter_rr_burst with a packet-level reference model
module tb_arbiter_rr_burst;
    localparam int NB = 32;
    localparam int N  = 3;
    localparam int BL = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]          ival, irdy;
    logic [N-1:0][NB-1:0]  imsg;
    logic                  oval, ordy;
    logic [AW+NB-1:0]      omsg;
    logic [AW-1:0]         gidx;
    logic                  busy;

    logic [3:0]            ival2, irdy2;
    logic [3:0][NB-1:0]    imsg2;
    logic                  oval2, ordy2;
    logic [2+NB-1:0]       omsg2;
    logic [1:0]            gidx2;
    logic                  busy2;

    arbiter_rr_burst #(.nbits(NB), .ninputs(N), .burst_len(BL)) dut (
        .clk(clk), .reset(reset),
        .istream_val(ival), .istream_rdy(irdy), .istream_msg(imsg),
        .ostream_val(oval), .ostream_rdy(ordy), .ostream_msg(omsg),
        .grant_idx(gidx), .busy(busy)
    );

    arbiter_rr_burst #(.nbits(NB), .ninputs(4), .burst_len(1)) dut4 (
        .clk(clk), .reset(reset),
        .istream_val(ival2), .istream_rdy(irdy2), .istream_msg(imsg2),
        .ostream_val(oval2), .ostream_rdy(ordy2), .ostream_msg(omsg2),
        .grant_idx(gidx2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;
    logic [AW+NB-1:0] exp_q[$];

    // Reference model: packet owner, beats remaining, rotation pointer, output register contents.
    bit               m_busy, m_oval;
    int               m_owner, m_left, m_ptr;
    logic [AW+NB-1:0] m_omsg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_oval = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_omsg = '0;
        exp_q.delete();
    endtask

    task automatic step(input logic [N-1:0] v, input logic r);
        logic [N-1:0] er;
        bit xfer;
        @(negedge clk);
        check("ostream_val", 64'(oval), 64'(m_oval));
        if (m_oval) check("ostream_msg", 64'(omsg), 64'(m_omsg));
        check("busy", 64'(busy), 64'(m_busy));
        if (m_busy) check("grant_idx", 64'(gidx), 64'(m_owner));
        ival = v;
        ordy = r;
        for (int i = 0; i < N; i++) imsg[i] = $urandom;
        #1;
        er = '0;
        if (m_busy && (!m_oval || r)) er[m_owner] = 1'b1;
        check("istream_rdy", 64'(irdy), 64'(er));
        xfer = m_busy && v[m_owner] && (!m_oval || r);
        if (xfer) begin
            m_omsg = {AW'(m_owner), imsg[m_owner]};
            exp_q.push_back(m_omsg);
            m_oval = 1;
        end else if (r) begin
            m_oval = 0;
        end
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (v[(m_ptr + k) % N]) begin
                    m_busy = 1; m_owner = (m_ptr + k) % N; m_left = BL;
                    break;
                end
            end
        end else if (xfer) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && oval && ordy) begin
                if (exp_q.size() == 0) check("scoreboard_unexpected_beat", 64'(omsg), 64'hffff_ffff_ffff_ffff);
                else check("scoreboard", 64'(omsg), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n, got;
        ival = '0; ordy = 1'b1; imsg = '0;
        ival2 = '0; ordy2 = 1'b1; imsg2 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ostream_val", 64'(oval), 0);
        check("rst_ostream_msg", 64'(omsg), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_grant", 64'(gidx), 0);
        check("rst_istream_rdy", 64'(irdy), 0);
        reset = 1'b1;

        repeat (10) step(3'b010, 1'b1);
        repeat (30) step(3'b111, 1'b1);
        for (int k = 0; k < 20; k++) step(3'b001, (k >= 4 && k < 7) ? 1'b0 : 1'b1);
        repeat (3) step(3'b101, 1'b1);
        repeat (5) step(3'b100, 1'b1);
        repeat (12) step(3'b101, 1'b1);
        repeat (2000) step(N'($urandom), ($urandom_range(0, 3) != 0));

        // Wrap: finish a src1 packet, then only src0 asks.
        n = 0;
        while (!(!m_busy && m_ptr == 2) && n < 200) begin step(3'b010, 1'b1); n++; end
        check("wrap_setup_timeout", 64'(n < 200), 1);
        step(3'b001, 1'b1);
        @(posedge clk); #1;
        check("wrap_grant_src0", 64'(gidx), 0);
        check("wrap_busy", 64'(busy), 1);

        // Async reset during beat 2 of a src0 packet.
        n = 0;
        while (!(m_busy && m_owner == 0 && m_left == BL - 2) && n < 200) begin step(3'b001, 1'b1); n++; end
        check("reset_setup_timeout", 64'(n < 200), 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_rst_ostream_val", 64'(oval), 0);
        check("async_rst_busy", 64'(busy), 0);
        check("async_rst_istream_rdy", 64'(irdy), 0);
        model_reset();
        ival = '0;
        @(negedge clk);
        reset = 1'b1;
        step(3'b110, 1'b1);
        @(posedge clk); #1;
        check("post_rst_grant_src1", 64'(gidx), 1);
        repeat (12) step(3'b110, 1'b1);
        repeat (6) step(3'b000, 1'b1);
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        // ninputs=4, burst_len=1: one beat per packet, grants rotate 0,1,2,3,0.
        for (int i = 0; i < 4; i++) imsg2[i] = NB'(32'h100 + i);
        ival2 = 4'hf;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            if (oval2) begin
                check("n4_grant_order", 64'(omsg2[NB+:2]), 64'(got % 4));
                check("n4_payload", 64'(omsg2[NB-1:0]), 64'(32'h100 + (got % 4)));
                got++;
            end
        end
        check("n4_beats_seen", 64'(got), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
